// File: rtl/multi_voice_osc.sv
// multi_voice_osc: time-multiplexed bank of NUM_VOICES phase-accumulator
// oscillators. One step_in strobe starts a sweep that processes one voice per
// cycle and emits its saw/pulse/triangle/silent sample one cycle later.
module multi_voice_osc #(
  parameter int NUM_VOICES = 8,
  parameter int WIDTH      = 32,
  localparam int VW        = $clog2(NUM_VOICES)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             step_in,
  input  logic             cfg_we_in,
  input  logic [VW-1:0]    cfg_voice_in,
  input  logic [WIDTH-1:0] cfg_incr_in,
  input  logic [1:0]       cfg_wave_in,
  input  logic [WIDTH-1:0] cfg_pw_in,
  input  logic             cfg_sync_in,
  output logic [WIDTH-1:0] sample_out,
  output logic [VW-1:0]    voice_out,
  output logic             valid_out,
  output logic             last_out,
  output logic             busy_out,
  output logic             overrun_out
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // MID is 2^(WIDTH-1): the sign bit, also the most negative sample value.
  localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [VW-1:0]    LAST_IDX = VW'(NUM_VOICES - 1);

  localparam logic [1:0] WAVE_SAW   = 2'd0;
  localparam logic [1:0] WAVE_PULSE = 2'd1;
  localparam logic [1:0] WAVE_TRI   = 2'd2;
  localparam logic [1:0] WAVE_OFF   = 2'd3;

  state_t           state_q, state_d;
  logic [VW-1:0]    idx_q, idx_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] phase_q [NUM_VOICES];
  logic [WIDTH-1:0] phase_d [NUM_VOICES];
  logic [WIDTH-1:0] incr_q  [NUM_VOICES];
  logic [WIDTH-1:0] incr_d  [NUM_VOICES];
  logic [1:0]       wave_q  [NUM_VOICES];
  logic [1:0]       wave_d  [NUM_VOICES];
  logic [WIDTH-1:0] pw_q    [NUM_VOICES];
  logic [WIDTH-1:0] pw_d    [NUM_VOICES];

  logic [WIDTH-1:0] sample_q, sample_d;
  logic [VW-1:0]    voice_q, voice_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             process;
  logic [WIDTH-1:0] cur_phase;
  logic [1:0]       cur_wave;
  logic [WIDTH-1:0] cur_pw;
  logic [WIDTH-1:0] tri_u;
  logic [WIDTH-1:0] tri_f;
  logic [WIDTH-1:0] new_sample;

  // Select the registered (pre-write, pre-increment) state of the voice under idx.
  always_comb begin
    cur_phase = '0;
    cur_wave  = WAVE_SAW;
    cur_pw    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (idx_q == VW'(v)) begin
        cur_phase = phase_q[v];
        cur_wave  = wave_q[v];
        cur_pw    = pw_q[v];
      end
    end
  end

  // Waveform shaping from the current phase; the triangle folds the doubled phase.
  always_comb begin
    tri_u = cur_phase << 1;
    tri_f = cur_phase[WIDTH-1] ? ~tri_u : tri_u;
    case (cur_wave)
      WAVE_SAW:   new_sample = cur_phase ^ MID;
      WAVE_PULSE: new_sample = (cur_phase < cur_pw) ? ~MID : MID;
      WAVE_TRI:   new_sample = tri_f ^ MID;
      default:    new_sample = '0;
    endcase
  end

  // Sweep sequencer: IDLE waits for step_in, RUN walks idx over every voice once.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    process   = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_in) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        process = 1'b1;
        if (step_in) begin
          overrun_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + VW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output stage: capture the processed sample; data holds, strobes drop when idle.
  always_comb begin
    sample_d = sample_q;
    voice_d  = voice_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    if (process) begin
      sample_d = new_sample;
      voice_d  = idx_q;
      valid_d  = 1'b1;
      last_d   = (idx_q == LAST_IDX);
    end
  end

  // Per-voice state: accumulate the processed voice, then apply config writes and sync on top.
  always_comb begin
    phase_d = phase_q;
    incr_d  = incr_q;
    wave_d  = wave_q;
    pw_d    = pw_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (process && (idx_q == VW'(v)) && (wave_q[v] != WAVE_OFF)) begin
        phase_d[v] = phase_q[v] + incr_q[v];
      end
      if (cfg_we_in && (cfg_voice_in == VW'(v))) begin
        incr_d[v] = cfg_incr_in;
        wave_d[v] = cfg_wave_in;
        pw_d[v]   = cfg_pw_in;
        if (cfg_sync_in) begin
          phase_d[v] = '0;
        end
      end
    end
  end

  // State registers with synchronous active-low reset; reset aborts any sweep.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      sample_q  <= '0;
      voice_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        incr_q[v]  <= '0;
        wave_q[v]  <= WAVE_SAW;
        pw_q[v]    <= MID;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      sample_q  <= sample_d;
      voice_q   <= voice_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      phase_q   <= phase_d;
      incr_q    <= incr_d;
      wave_q    <= wave_d;
      pw_q      <= pw_d;
    end
  end

  assign sample_out  = sample_q;
  assign voice_out   = voice_q;
  assign valid_out   = valid_q;
  assign last_out    = last_q;
  assign busy_out    = (state_q == RUN);
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_multi_voice_osc.sv
// Testbench for multi_voice_osc (4 voices, 32-bit). A time-based reference
// model predicts every output each cycle; directed sections add fixed-value checks.
module tb_multi_voice_osc;

  localparam int NV = 4;
  localparam int W  = 32;
  localparam int VW = 2;
  localparam longint unsigned FULL = 64'h1_0000_0000;
  localparam longint unsigned HALF = 64'h8000_0000;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          step_in;
  logic          cfg_we_in;
  logic [VW-1:0] cfg_voice_in;
  logic [W-1:0]  cfg_incr_in;
  logic [1:0]    cfg_wave_in;
  logic [W-1:0]  cfg_pw_in;
  logic          cfg_sync_in;
  logic [W-1:0]  sample_out;
  logic [VW-1:0] voice_out;
  logic          valid_out;
  logic          last_out;
  logic          busy_out;
  logic          overrun_out;

  multi_voice_osc #(.NUM_VOICES(NV), .WIDTH(W)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .step_in      (step_in),
    .cfg_we_in    (cfg_we_in),
    .cfg_voice_in (cfg_voice_in),
    .cfg_incr_in  (cfg_incr_in),
    .cfg_wave_in  (cfg_wave_in),
    .cfg_pw_in    (cfg_pw_in),
    .cfg_sync_in  (cfg_sync_in),
    .sample_out   (sample_out),
    .voice_out    (voice_out),
    .valid_out    (valid_out),
    .last_out     (last_out),
    .busy_out     (busy_out),
    .overrun_out  (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Reference model: voice settings plus the edge number at which the current sweep started.
  logic [W-1:0] m_phase [NV];
  logic [W-1:0] m_incr  [NV];
  logic [1:0]   m_wave  [NV];
  logic [W-1:0] m_pw    [NV];
  int           edge_no = 0;
  int           sweep_start = -100;
  bit           m_overrun = 1'b0;
  logic [W-1:0] exp_sample = '0;
  logic [VW-1:0] exp_voice = '0;
  bit           exp_valid = 1'b0;
  bit           exp_last = 1'b0;
  bit           exp_busy = 1'b0;

  logic [W-1:0] got_v0[$];
  int           valid_seen = 0;

  // Sample value from the waveform definitions, using plain integer arithmetic.
  function automatic logic [W-1:0] refSample(logic [W-1:0] phase, logic [1:0] wave, logic [W-1:0] pw);
    longint unsigned p = {32'd0, phase};
    longint unsigned f;
    case (wave)
      2'd0: return W'((p + FULL - HALF) % FULL);
      2'd1: return (phase < pw) ? W'(HALF - 1) : W'(HALF);
      2'd2: begin
        f = (p < HALF) ? 2 * p : (2 * FULL - 1 - 2 * p);
        return W'((f + FULL - HALF) % FULL);
      end
      default: return '0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  // Advance the model by one clock edge given the inputs applied at that edge.
  task automatic modelEdge(bit rst_n, bit step, bit we, logic [VW-1:0] voice,
                           logic [W-1:0] incr, logic [1:0] wave, logic [W-1:0] pw, bit sync);
    int rel;
    int v;
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) begin
        m_phase[i] = '0;
        m_incr[i]  = '0;
        m_wave[i]  = 2'd0;
        m_pw[i]    = W'(HALF);
      end
      sweep_start = edge_no - 100;
      m_overrun   = 1'b0;
      exp_sample  = '0;
      exp_voice   = '0;
      exp_valid   = 1'b0;
      exp_last    = 1'b0;
      exp_busy    = 1'b0;
      edge_no++;
      return;
    end
    rel       = edge_no - sweep_start;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    if (rel >= 1 && rel <= NV) begin
      v          = rel - 1;
      exp_sample = refSample(m_phase[v], m_wave[v], m_pw[v]);
      exp_voice  = VW'(v);
      exp_valid  = 1'b1;
      exp_last   = (v == NV - 1);
      if (m_wave[v] != 2'd3) m_phase[v] = m_phase[v] + m_incr[v];
    end
    if (step) begin
      if (rel >= 1 && rel <= NV) m_overrun = 1'b1;
      else sweep_start = edge_no;
    end
    if (we) begin
      m_incr[voice] = incr;
      m_wave[voice] = wave;
      m_pw[voice]   = pw;
      if (sync) m_phase[voice] = '0;
    end
    exp_busy = (edge_no - sweep_start) >= 0 && (edge_no - sweep_start) <= NV - 1;
    edge_no++;
  endtask

  task automatic checkOutput();
    chk("valid_out",   {31'd0, valid_out},   {31'd0, exp_valid});
    chk("last_out",    {31'd0, last_out},    {31'd0, exp_last});
    chk("busy_out",    {31'd0, busy_out},    {31'd0, exp_busy});
    chk("overrun_out", {31'd0, overrun_out}, {31'd0, m_overrun});
    chk("sample_out",  sample_out,           exp_sample);
    chk("voice_out",   {30'd0, voice_out},   {30'd0, exp_voice});
    if (valid_out === 1'b1) valid_seen++;
    if (valid_out === 1'b1 && voice_out === 2'd0) got_v0.push_back(sample_out);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare away from the edge.
  task automatic applyStimulus(bit rst_n, bit step, bit we, logic [VW-1:0] voice,
                               logic [W-1:0] incr, logic [1:0] wave, logic [W-1:0] pw, bit sync);
    rst_n_in     = rst_n;
    step_in      = step;
    cfg_we_in    = we;
    cfg_voice_in = voice;
    cfg_incr_in  = incr;
    cfg_wave_in  = wave;
    cfg_pw_in    = pw;
    cfg_sync_in  = sync;
    @(posedge clk_in);
    modelEdge(rst_n, step, we, voice, incr, wave, pw, sync);
    #1;
    checkOutput();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 2'd0, '0, 1'b0);
  endtask

  task automatic stepOnce();
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 2'd0, '0, 1'b0);
  endtask

  task automatic cfgWrite(logic [VW-1:0] voice, logic [W-1:0] incr, logic [1:0] wave,
                          logic [W-1:0] pw, bit sync);
    applyStimulus(1'b1, 1'b0, 1'b1, voice, incr, wave, pw, sync);
  endtask

  task automatic doReset(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] saw_exp [5];
    saw_exp[0] = 32'h8000_0000;
    saw_exp[1] = 32'hC000_0000;
    saw_exp[2] = 32'h0000_0000;
    saw_exp[3] = 32'h4000_0000;
    saw_exp[4] = 32'h8000_0000;

    // Reset state.
    doReset(2);

    // Saw on voice 0: five sweeps spaced eight cycles apart.
    cfgWrite(2'd0, 32'h4000_0000, 2'd0, 32'h8000_0000, 1'b0);
    got_v0.delete();
    for (int i = 0; i < 5; i++) begin
      stepOnce();
      idle(7);
    end
    chk("saw_v0_count", got_v0.size(), 5);
    for (int i = 0; i < 5 && i < got_v0.size(); i++) chk("saw_v0_value", got_v0[i], saw_exp[i]);

    // Sweep timing: exactly four valid samples from one step.
    valid_seen = 0;
    stepOnce();
    idle(8);
    chk("sweep_valid_count", valid_seen, NV);

    // Pulse on voice 1, triangle on voice 2.
    cfgWrite(2'd1, 32'h4000_0000, 2'd1, 32'h8000_0000, 1'b0);
    cfgWrite(2'd2, 32'h4000_0000, 2'd2, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepOnce();
      idle(6);
    end

    // Off: voice 3 holds phase while silent, then resumes as saw.
    cfgWrite(2'd3, 32'h1000_0000, 2'd0, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 2; i++) begin stepOnce(); idle(5); end
    cfgWrite(2'd3, 32'h1000_0000, 2'd3, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 2; i++) begin stepOnce(); idle(5); end
    cfgWrite(2'd3, 32'h1000_0000, 2'd0, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 2; i++) begin stepOnce(); idle(5); end

    // Sync written in the very cycle voice 2 is processed.
    stepOnce();
    idle(2);
    cfgWrite(2'd2, 32'h4000_0000, 2'd2, 32'h8000_0000, 1'b1);
    idle(4);
    stepOnce();
    idle(5);

    // Config write to voice 1 while it is being processed uses the old setting.
    stepOnce();
    idle(1);
    cfgWrite(2'd1, 32'h2000_0000, 2'd0, 32'h8000_0000, 1'b0);
    idle(4);

    // Reset mid-sweep, then a clean sweep from reset phases.
    stepOnce();
    idle(2);
    doReset(1);
    chk("midreset_valid", {31'd0, valid_out}, 32'd0);
    idle(2);
    stepOnce();
    idle(6);

    // Overrun: second step two cycles into the sweep.
    cfgWrite(2'd0, 32'h0123_4567, 2'd2, 32'h8000_0000, 1'b0);
    valid_seen = 0;
    stepOnce();
    idle(1);
    stepOnce();
    chk("overrun_set", {31'd0, overrun_out}, 32'd1);
    idle(10);
    chk("overrun_valid_count", valid_seen, NV);
    chk("overrun_sticky", {31'd0, overrun_out}, 32'd1);

    // Step exactly NV+1 cycles after the previous one is accepted without overrun.
    doReset(1);
    stepOnce();
    idle(NV);
    stepOnce();
    idle(NV + 2);
    chk("spacing_no_overrun", {31'd0, overrun_out}, 32'd0);

    // Randomized traffic: steps, config writes, syncs and rare resets at arbitrary times.
    for (int i = 0; i < 400; i++) begin
      bit rn;
      bit st;
      bit we;
      bit sy;
      rn = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 5) == 0);
      we = ($urandom_range(0, 3) == 0);
      sy = ($urandom_range(0, 7) == 0);
      applyStimulus(rn, st, we, VW'($urandom_range(0, NV - 1)), $urandom,
                    2'($urandom_range(0, 3)), $urandom, sy);
    end
    idle(NV + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
